// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW into lane strobes and lane-placed data, queues them,
// and drains one write at a time over a req/addr_ok/data_ok bus. Flags load address hits.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [7:0]  st_aluop,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_device,
    output logic        st_ade,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty,
    output logic        data_req,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_ok
);

    localparam logic [7:0] OP_SB = 8'h38;
    localparam logic [7:0] OP_SH = 8'h39;
    localparam logic [7:0] OP_SW = 8'h3A;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [29:0] word;
        logic [3:0]  strb;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t         state, state_next;
    entry_t         mem [DEPTH];
    entry_t         fmt, head_next;
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_adv;
    logic [CW-1:0]  count, count_next;
    logic           legal, misaligned, push, pop, load_head;
    logic [AW-1:0]  offset;
    logic [1:0]     unused_ld_low;

    assign unused_ld_low = ld_addr[1:0];

    // Store formatting: lane order matches the load-side extractor
    always_comb begin
        fmt        = '0;
        fmt.word   = st_addr[31:2];
        legal      = 1'b0;
        misaligned = 1'b0;
        case (st_aluop)
            OP_SW: begin
                legal      = 1'b1;
                misaligned = (st_addr[1:0] != 2'b00);
                fmt.strb   = 4'b1111;
                fmt.data   = st_device ? st_data
                           : {st_data[7:0], st_data[15:8], st_data[23:16], st_data[31:24]};
            end
            OP_SH: begin
                legal      = 1'b1;
                misaligned = st_addr[0];
                fmt.strb   = st_addr[1] ? 4'b0011 : 4'b1100;
                fmt.data   = st_addr[1] ? {16'h0000, st_data[7:0], st_data[15:8]}
                                        : {st_data[7:0], st_data[15:8], 16'h0000};
            end
            OP_SB: begin
                legal    = 1'b1;
                fmt.strb = 4'b1000 >> st_addr[1:0];
                fmt.data = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign st_ade   = st_valid & legal & misaligned;
    assign st_ready = (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = st_valid & st_ready & legal & ~misaligned;
    assign rd_adv   = rd_ptr + AW'(1);

    // Any queued entry, including the head in flight, matches on word address
    always_comb begin
        ld_hit = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr;
            if ((CW'(offset) < count) && (mem[i].word == ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    // Drain FSM next-state and pop
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: if (count != '0) state_next = S_ADDR;
            S_ADDR: if (data_addr_ok) state_next = S_DATA;
            S_DATA: if (data_ok) pop = 1'b1;
            default: state_next = S_IDLE;
        endcase
        count_next = count + CW'(push) - CW'(pop);
        if (pop)
            state_next = (count_next != '0) ? S_ADDR : S_IDLE;
    end

    // Next head: after a pop with only the incoming store left, bypass the write port
    always_comb begin
        load_head = (state_next == S_ADDR) && (state != S_ADDR);
        if (state == S_DATA)
            head_next = (push && (wr_ptr == rd_adv)) ? fmt : mem[rd_adv];
        else
            head_next = mem[rd_ptr];
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (push) mem[wr_ptr] <= fmt;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state      <= S_IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_req   <= 1'b0;
            data_wstrb <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            data_req <= (state_next == S_ADDR);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_adv;
            if (load_head) begin
                data_wstrb <= head_next.strb;
                data_addr  <= {head_next.word, 2'b00};
                data_wdata <= head_next.data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: formatting, FIFO full/ordering, ld_hit, bypass, reset.
module tb_store_buffer;

    localparam logic [7:0] OP_SB = 8'h38;
    localparam logic [7:0] OP_SH = 8'h39;
    localparam logic [7:0] OP_SW = 8'h3A;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready, st_device, st_ade, ld_hit, empty;
    logic [7:0]  st_aluop;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        data_req, data_addr_ok, data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;

    int vectors = 0;
    int errors  = 0;

    store_buffer #(.DEPTH(4), .AW(2)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_aluop    (st_aluop),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_device   (st_device),
        .st_ade      (st_ade),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .empty       (empty),
        .data_req    (data_req),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_ok     (data_ok)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic dev);
        st_valid  = 1'b1;
        st_aluop  = op;
        st_addr   = a;
        st_data   = d;
        st_device = dev;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (data_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_req"}, 32'(data_req), 32'd1);
    endtask

    // Wait for the request, check the bus, then complete addr and data phases
    task automatic xfer(input string tag, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] w);
        wait_req(tag);
        check({tag, "_strb"}, 32'(data_wstrb), 32'(s));
        check({tag, "_addr"}, data_addr, a);
        check({tag, "_wdata"}, data_wdata, w);
        data_addr_ok = 1'b1;
        cyc();
        data_addr_ok = 1'b0;
        check({tag, "_data_req0"}, 32'(data_req), 32'd0);
        check({tag, "_hold"}, data_wdata, w);
        data_ok = 1'b1;
        cyc();
        data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_aluop = 8'h00; st_addr = '0; st_data = '0;
        st_device = 1'b0; ld_addr = 32'hFFFF_FFF0; data_addr_ok = 1'b0; data_ok = 1'b0;
        cyc(); cyc();
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_strb", 32'(data_wstrb), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_hit", 32'(ld_hit), 32'd0);
        rst = 1'b0;
        cyc();

        // SW, memory space: byte-swapped
        offer(OP_SW, 32'h100, 32'h1122_3344, 1'b0);
        #1 check("sw_ade", 32'(st_ade), 32'd0);
        cyc(); st_valid = 1'b0;
        check("sw_latency_req", 32'(data_req), 32'd0);
        check("sw_not_empty", 32'(empty), 32'd0);
        xfer("sw", 4'b1111, 32'h100, 32'h4433_2211);
        check("sw_empty_after", 32'(empty), 32'd1);

        offer(OP_SH, 32'h102, 32'h0000_BEEF, 1'b0);
        cyc(); st_valid = 1'b0;
        xfer("sh_hi", 4'b0011, 32'h100, 32'h0000_EFBE);

        offer(OP_SH, 32'h0, 32'hFFFF_1234, 1'b0);
        cyc(); st_valid = 1'b0;
        xfer("sh_lo", 4'b1100, 32'h0, 32'h3412_0000);

        offer(OP_SB, 32'h101, 32'h1234_565A, 1'b0);
        cyc(); st_valid = 1'b0;
        xfer("sb", 4'b0100, 32'h100, 32'h5A5A_5A5A);

        offer(OP_SW, 32'h104, 32'hCAFE_F00D, 1'b1);
        cyc(); st_valid = 1'b0;
        xfer("sw_dev", 4'b1111, 32'h104, 32'hCAFE_F00D);

        // Misaligned stores raise st_ade and never enqueue
        offer(OP_SW, 32'h103, 32'hDEAD_BEEF, 1'b0);
        #1 check("sw_ade1", 32'(st_ade), 32'd1);
        cyc();
        offer(OP_SH, 32'h101, 32'hDEAD_BEEF, 1'b0);
        #1 check("sh_ade1", 32'(st_ade), 32'd1);
        cyc(); st_valid = 1'b0;
        check("ade_empty", 32'(empty), 32'd1);
        cyc();
        check("ade_no_req", 32'(data_req), 32'd0);

        // Fill with the bus stalled, fifth store is held off
        offer(OP_SB, 32'h10, 32'h01, 1'b0); cyc();
        offer(OP_SB, 32'h21, 32'h02, 1'b0); cyc();
        offer(OP_SB, 32'h32, 32'h03, 1'b0); cyc();
        offer(OP_SB, 32'h43, 32'h04, 1'b0); cyc();
        check("full_ready0", 32'(st_ready), 32'd0);
        offer(OP_SB, 32'h54, 32'h05, 1'b0);
        cyc();
        check("full_still0", 32'(st_ready), 32'd0);
        check("full_req_head", data_addr, 32'h10);
        cyc();
        check("full_stable", data_wstrb, 32'h8);
        xfer("q1", 4'b1000, 32'h10, 32'h0101_0101);
        check("ready_back", 32'(st_ready), 32'd1);
        cyc(); st_valid = 1'b0;
        xfer("q2", 4'b0100, 32'h20, 32'h0202_0202);
        xfer("q3", 4'b0010, 32'h30, 32'h0303_0303);
        xfer("q4", 4'b0001, 32'h40, 32'h0404_0404);
        xfer("q5", 4'b1000, 32'h54, 32'h0505_0505);
        check("q_empty", 32'(empty), 32'd1);

        // ld_hit on a pending store
        offer(OP_SW, 32'h200, 32'h1, 1'b1);
        cyc(); st_valid = 1'b0;
        ld_addr = 32'h203; #1 check("hit_203", 32'(ld_hit), 32'd1);
        ld_addr = 32'h204; #1 check("hit_204", 32'(ld_hit), 32'd0);
        ld_addr = 32'h1FC; #1 check("hit_1fc", 32'(ld_hit), 32'd0);
        ld_addr = 32'h200;
        wait_req("hit");
        data_addr_ok = 1'b1; cyc(); data_addr_ok = 1'b0;
        check("hit_in_data", 32'(ld_hit), 32'd1);
        data_ok = 1'b1; cyc(); data_ok = 1'b0;
        check("hit_cleared", 32'(ld_hit), 32'd0);

        // Push and pop in the same cycle with a single entry: new store goes straight out
        offer(OP_SB, 32'h300, 32'h77, 1'b0);
        cyc(); st_valid = 1'b0;
        wait_req("byp0");
        data_addr_ok = 1'b1; cyc(); data_addr_ok = 1'b0;
        data_ok = 1'b1;
        offer(OP_SW, 32'h304, 32'hA5A5_0001, 1'b1);
        cyc(); data_ok = 1'b0; st_valid = 1'b0;
        check("byp_req", 32'(data_req), 32'd1);
        check("byp_empty", 32'(empty), 32'd0);
        xfer("byp", 4'b1111, 32'h304, 32'hA5A5_0001);
        check("byp_done", 32'(empty), 32'd1);

        // Reset in DATA with three entries, then a stray data_ok
        offer(OP_SB, 32'h400, 32'h11, 1'b0); cyc();
        offer(OP_SB, 32'h401, 32'h22, 1'b0); cyc();
        offer(OP_SB, 32'h402, 32'h33, 1'b0); cyc();
        st_valid = 1'b0;
        wait_req("rst_mid");
        data_addr_ok = 1'b1; cyc(); data_addr_ok = 1'b0;
        check("rst_mid_busy", 32'(empty), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; data_ok = 1'b1;
        check("rst_mid_req", 32'(data_req), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_strb", 32'(data_wstrb), 32'd0);
        check("rst_mid_ready", 32'(st_ready), 32'd1);
        cyc(); data_ok = 1'b0;
        ld_addr = 32'h400;
        #1 check("stray_hit", 32'(ld_hit), 32'd0);
        check("stray_empty", 32'(empty), 32'd1);
        cyc();
        check("stray_req", 32'(data_req), 32'd0);
        check("stray_ready", 32'(st_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
